// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised full-duplex SPI master, all four CPOL/CPHA modes
// spi_clk is a registered output derived from a clk-domain divider; never used as a clock.
module spi_master_param #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 2,
  parameter int NUM_CS   = 2,
  parameter int CS_SEL_W = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   data_wr,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [CS_SEL_W-1:0] cs_sel,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   data_rd,
  output logic                spi_clk,
  output logic [NUM_CS-1:0]   cs_n,
  output logic                mosi,
  input  logic                miso
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic                cpol_q;
  logic                cpha_q;
  logic                tick;
  logic                sample_edge;
  logic [NUM_CS-1:0]   cs_dec;

  assign tick = (div_cnt == DIV_LAST);
  // edge_cnt even -> this toggle is a leading edge; CPHA flips which edge samples
  assign sample_edge = ~edge_cnt[0] ^ cpha_q;

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_SEL_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_rd  <= '0;
      spi_clk  <= 1'b0;
      cs_n     <= '1;
      mosi     <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state != IDLE) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETUP;
            busy     <= 1'b1;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            spi_clk  <= cpol;
            cs_n     <= cs_dec;
            div_cnt  <= '0;
            edge_cnt <= '0;
            if (cpha) begin
              tx_sr <= data_wr;
            end else begin
              mosi  <= data_wr[DATA_W-1];
              tx_sr <= {data_wr[DATA_W-2:0], 1'b0};
            end
          end else begin
            spi_clk <= cpol_q;
          end
        end
        SETUP: if (tick) state <= XFER;
        XFER: begin
          if (tick) begin
            spi_clk  <= ~spi_clk;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (sample_edge) begin
              rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end else if (cpha_q || edge_cnt != EDGE_LAST) begin
              // CPHA=0 already presented the MSB in SETUP, so its last trailing edge launches nothing
              mosi  <= tx_sr[DATA_W-1];
              tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (edge_cnt == EDGE_LAST) state <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            state   <= DONE;
            done    <= 1'b1;
            data_rd <= rx_sr;
            cs_n    <= '1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - directed scoreboard bench for spi_master_param
// Instance a: 8-bit, div 2; instance b: 16-bit, div 1, 2-bit cs_sel.
module tb_spi_master_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0;
  logic [7:0] wr_a = '0;
  logic       cpol_a = 1'b0;
  logic       cpha_a = 1'b0;
  logic [0:0] cs_a = '0;
  logic       busy_a, done_a, sclk_a, mosi_a, miso_a;
  logic [7:0] rd_a;
  logic [1:0] csn_a;
  logic       loop_a = 1'b1;
  logic       slv_miso = 1'b0;
  assign miso_a = loop_a ? mosi_a : slv_miso;

  logic        start_b = 1'b0;
  logic [15:0] wr_b = '0;
  logic        cpol_b = 1'b0;
  logic        cpha_b = 1'b0;
  logic [1:0]  cs_b = '0;
  logic        busy_b, done_b, sclk_b, mosi_b;
  logic [15:0] rd_b;
  logic [1:0]  csn_b;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(2), .CS_SEL_W(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data_wr(wr_a), .cpol(cpol_a), .cpha(cpha_a),
    .cs_sel(cs_a), .busy(busy_a), .done(done_a), .data_rd(rd_a), .spi_clk(sclk_a),
    .cs_n(csn_a), .mosi(mosi_a), .miso(miso_a));

  spi_master_param #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(2), .CS_SEL_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data_wr(wr_b), .cpol(cpol_b), .cpha(cpha_b),
    .cs_sel(cs_b), .busy(busy_b), .done(done_b), .data_rd(rd_b), .spi_clk(sclk_b),
    .cs_n(csn_b), .mosi(mosi_b), .miso(mosi_b));

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];

  // slave model / line monitor for instance a, evaluated away from the active edge
  logic       m_cpol = 1'b0, m_cpha = 1'b0;
  logic [7:0] slv_word = '0, sreg = '0, cap = '0;
  logic       p_clk = 1'b0, p_mosi = 1'b1;
  logic [1:0] p_cs = 2'b11;
  int         edge_bad = 0;
  bit         seen_one = 0;

  always @(negedge clk) begin
    logic cs_low, smp;
    cs_low = (csn_a != 2'b11) && (p_cs != 2'b11);
    smp = (sclk_a != m_cpol) ^ m_cpha;
    if (p_cs == 2'b11 && csn_a != 2'b11) begin
      sreg = slv_word;
      if (!m_cpha) begin slv_miso = sreg[7]; sreg = {sreg[6:0], 1'b0}; end
    end
    if (cs_low) begin
      if (sclk_a != p_clk) begin
        if (smp) cap = {cap[6:0], mosi_a};
        else begin slv_miso = sreg[7]; sreg = {sreg[6:0], 1'b0}; end
      end
      if (mosi_a != p_mosi && (sclk_a == p_clk || smp)) edge_bad++;
      if (mosi_a) seen_one = 1;
    end
    p_clk = sclk_a; p_mosi = mosi_a; p_cs = csn_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic start_xa(input logic [7:0] wd, input logic cp, input logic ch, input logic [0:0] cs);
    @(negedge clk);
    start_a = 1'b1; wr_a = wd; cpol_a = cp; cpha_a = ch; cs_a = cs;
    m_cpol = cp; m_cpha = ch; cap = '0; edge_bad = 0; seen_one = 0;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int from, output int lat);
    lat = from;
    while (!done_a && lat < 300) begin @(negedge clk); lat++; end
  endtask

  task automatic xfer_b(input logic [1:0] cs, input logic [1:0] exp_cs, input string tag);
    int lat;
    logic [1:0] cs_and;
    sb.push_back(32'h0000BEEF);
    @(negedge clk);
    start_b = 1'b1; wr_b = 16'hBEEF; cs_b = cs;
    @(negedge clk);
    start_b = 1'b0; lat = 1; cs_and = csn_b;
    while (!done_b && lat < 300) begin @(negedge clk); lat++; cs_and = cs_and & csn_b; end
    chk({tag, "_lat"}, lat, 35);
    chk({tag, "_data"}, {16'b0, rd_b}, sb.pop_front());
    chk({tag, "_cs"}, {30'b0, cs_and}, {30'b0, exp_cs});
  endtask

  initial begin
    int lat, dcount, k, c;
    int t[3];
    logic pdone;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", {30'b0, csn_a}, 32'h3);
    chk("rst_sclk", {31'b0, sclk_a}, 0);
    chk("rst_mosi", {31'b0, mosi_a}, 1);
    chk("rst_busy", {31'b0, busy_a}, 0);
    chk("rst_done", {31'b0, done_a}, 0);
    chk("rst_data", {24'b0, rd_a}, 0);
    reset = 1'b0;

    // mode 0 loopback
    sb.push_back(32'hA5);
    start_xa(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    chk("t1_cs_n", {30'b0, csn_a}, 32'h2);
    chk("t1_busy", {31'b0, busy_a}, 1);
    wait_done_a(10, lat);
    chk("t1_lat", lat, 37);
    chk("t1_data", {24'b0, rd_a}, sb.pop_front());
    chk("t1_mosi_bits", {24'b0, cap}, 32'hA5);
    chk("t1_edges", edge_bad, 0);

    // all four modes against the slave model
    loop_a = 1'b0;
    slv_word = 8'h3C;
    for (int m = 0; m < 4; m++) begin
      sb.push_back(32'h3C);
      start_xa(8'hC3, m[1], m[0], 1'b0);
      wait_done_a(1, lat);
      chk("t2_lat", lat, 37);
      chk("t2_data", {24'b0, rd_a}, sb.pop_front());
      chk("t2_mosi_bits", {24'b0, cap}, 32'hC3);
      chk("t2_edges", edge_bad, 0);
      @(negedge clk);
      chk("t2_idle_sclk", {31'b0, sclk_a}, {31'b0, m[1]});
    end

    // reset mid-transfer
    loop_a = 1'b1;
    start_xa(8'h5A, 1'b1, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t3_cs_n", {30'b0, csn_a}, 32'h3);
    chk("t3_sclk", {31'b0, sclk_a}, 0);
    chk("t3_busy", {31'b0, busy_a}, 0);
    chk("t3_mosi", {31'b0, mosi_a}, 1);
    dcount = 0;
    repeat (60) begin @(negedge clk); if (done_a) dcount++; end
    chk("t3_no_done", dcount, 0);
    sb.push_back(32'h5A);
    start_xa(8'h5A, 1'b1, 1'b0, 1'b0);
    wait_done_a(1, lat);
    chk("t3_lat", lat, 37);
    chk("t3_data", {24'b0, rd_a}, sb.pop_front());

    // start while busy, mid-transfer and in DONE
    sb.push_back(32'h00);
    start_xa(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    start_a = 1'b1; wr_a = 8'hFF; cpha_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(12, lat);
    chk("t4_lat", lat, 37);
    chk("t4_data", {24'b0, rd_a}, sb.pop_front());
    chk("t4_mosi_zero", {31'b0, seen_one}, 0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    dcount = 0;
    repeat (60) begin @(negedge clk); if (done_a) dcount++; end
    chk("t4_no_done", dcount, 0);
    chk("t4_idle_busy", {31'b0, busy_a}, 0);

    // start held high: back-to-back transfers
    repeat (3) sb.push_back(32'h96);
    @(negedge clk);
    start_a = 1'b1; wr_a = 8'h96; cpol_a = 1'b0; cpha_a = 1'b0; cs_a = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0;
    k = 0; c = 0; pdone = 1'b0;
    while (k < 3 && c < 300) begin
      @(negedge clk);
      c++;
      if (pdone) chk("t5_gap_idle_cs", {30'b0, csn_a}, 32'h3);
      pdone = done_a;
      if (done_a) begin
        t[k] = c;
        chk("t5_gap_done_cs", {30'b0, csn_a}, 32'h3);
        chk("t5_data", {24'b0, rd_a}, sb.pop_front());
        k++;
        if (k == 3) start_a = 1'b0;
      end
    end
    start_a = 1'b0;
    chk("t5_count", k, 3);
    chk("t5_first", t[0], 37);
    chk("t5_space1", t[1] - t[0], 38);
    chk("t5_space2", t[2] - t[1], 38);

    // 16-bit, div 1 instance
    repeat (5) @(negedge clk);
    xfer_b(2'd1, 2'b01, "t6_cs1");
    xfer_b(2'd3, 2'b11, "t6_cs3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
